serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder built on the existing `full_adder` cell plus a carry flip-flop. It adds two WIDTH-bit operands LSB-first, one bit per clock.
- It is the sequential stage directly downstream of `full_adder`: it consumes `result` and `carry_out` every cycle and feeds `carry_out` back as the next `carry_in`.
- It is the first area-minimal ALU datapath option in the nand_to_cpu build-up.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- sub  input  1  subtract request; captured on accepted start; ignored unless SERIAL_ADDER_SUB_EN
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse, high in DONE
- sum  output  WIDTH  registered result; holds until next completion
- carry_out  output  1  registered final carry; holds with sum

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - Reset `rst` is synchronous and active-high. On a `clk` edge with `rst`=1: state=IDLE, busy=0, done=0, sum=0, carry_out=0, shift registers=0, bit counter=0, carry FF=0.
  - `rst` overrides all other inputs. Reset mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - Accepted start: the edge where state=IDLE and start=1.
  - On that edge: a_sr<=a, b_sr<=b, carry FF<=0 (add), count<=0, state<=RUN.
  - Otherwise remain in IDLE.
- RUN (busy=1):
  - Each edge drives the full_adder with a_sr[0], b_sr[0] and the carry FF.
  - The adder's result shifts into res_sr at the MSB end (res_sr shifts right).
  - a_sr and b_sr shift right, zero-filled. Carry FF<=full_adder carry_out. count<=count+1.
  - On the edge where count==WIDTH-1, this bit is still processed, then state<=DONE.
  - On that same edge: sum<=final shifted result, carry_out<=final carry.
- DONE:
  - done=1 for exactly one cycle; state<=IDLE unconditionally.
  - start is ignored in DONE and in RUN; it is not queued.
- Latency:
  - If start is accepted at edge k, done is high in the cycle following edge k+WIDTH.
  - Throughput: one operation per WIDTH+2 cycles.
- Output timing:
  - sum and carry_out change only on the edge entering DONE; they are stable in the DONE cycle and remain stable afterwards.
  - a, b and sub may change freely after acceptance.
- Arithmetic: {carry_out,sum} = a+b modulo 2^(WIDTH+1).
- Counter: width $clog2(WIDTH+1). WIDTH=1 is legal: one RUN cycle, then DONE.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - sub is captured on acceptance.
  - If sub=1: b_sr loads ~b and the carry FF initialises to 1.
  - Result: sum = a-b mod 2^WIDTH; carry_out=1 means no borrow (a>=b unsigned).
- Undefined:
  - The sub port exists but is ignored; the block always adds.
  - No inverter or sub register is synthesised.

Decomposition:
- Package serial_adder_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} serial_adder_state_t
  - localparam MAX_WIDTH=64
- Sub-module: one instance of the existing full_adder (ports a, b, carry_in, result, carry_out). No other sub-modules.
- Elaboration-time $fatal if WIDTH<1 or WIDTH>MAX_WIDTH.

Test Plan:
- WIDTH=8, start with a=0x00, b=0x00 -> done pulse; sum=0x00, carry_out=0; busy high for exactly 8 cycles.
- a=0x3C, b=0x55 -> sum=0x91, carry_out=0; done high in the cycle after edge k+8 and low the next cycle.
- a=0xFF, b=0x01 -> sum=0x00, carry_out=1. Then start with a=0x80, b=0x80 -> sum=0x00, carry_out=1; sum holds between operations.
- start held high continuously, with a/b changed mid-RUN -> result uses operands captured at acceptance. A new op is accepted only in IDLE, so done pulses are spaced WIDTH+2 cycles apart.
- rst asserted at RUN bit 4 of a=0xAA, b=0x55 -> next cycle busy=0, done=0, sum=0, carry_out=0, and no done pulse follows. A fresh start then yields sum=0xFF, carry_out=0.
- With SERIAL_ADDER_SUB_EN and sub=1:
  - a=0x05, b=0x07 -> sum=0xFE, carry_out=0.
  - a=0x07, b=0x05 -> sum=0x02, carry_out=1.
  - Without the macro, the same stimulus gives sum=0x0C, carry_out=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {IDLE, RUN, DONE} serial_adder_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell: combinational sum and carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic result,
  output logic carry_out
);

  assign result    = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder plus a carry flip-flop, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to honour the sub input (two's-complement subtract).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "serial_adder: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end

  serial_adder_state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_sr_q;
  logic [CntW-1:0]  count_q;
  logic             carry_q;

  logic             fa_result;
  logic             fa_carry;
  logic [WIDTH:0]   res_ext;
  logic [WIDTH-1:0] res_shift;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             carry_init;

  full_adder u_full_adder (
    .a         (a_sr_q[0]),
    .b         (b_sr_q[0]),
    .carry_in  (carry_q),
    .result    (fa_result),
    .carry_out (fa_carry)
  );

  // Widened concat keeps the right shift legal when WIDTH is 1.
  assign res_ext   = {fa_result, res_sr_q};
  assign res_shift = res_ext[WIDTH:1];
  assign last_bit  = (count_q == LastCnt);

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      res_sr_q  <= '0;
      count_q   <= '0;
      carry_q   <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b_load;
            carry_q <= carry_init;
            count_q <= '0;
          end
        end
        RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= res_shift;
          carry_q  <= fa_carry;
          count_q  <= count_q + CntW'(1);
          if (last_bit) begin
            sum       <= res_shift;
            carry_out <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one op and watch 12 cycles: busy count, done position, result.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic ts, input logic [W-1:0] es, input logic ec);
    int busy_cnt;
    int done_idx;
    int done_cnt;
    logic [W-1:0] s_at_done;
    logic         c_at_done;
    busy_cnt  = 0;
    done_idx  = -1;
    done_cnt  = 0;
    s_at_done = 'x;
    c_at_done = 1'bx;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = ~ta; b = ~tb_v; sub = ~ts;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
        s_at_done = sum;
        c_at_done = carry_out;
      end
    end
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(8));
    chk({tag, "_done_idx"}, 64'(done_idx), 64'(9));
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
    chk({tag, "_sum"}, 64'(s_at_done), 64'(es));
    chk({tag, "_cout"}, 64'(c_at_done), 64'(ec));
    chk({tag, "_sum_hold"}, 64'(sum), 64'(es));
    chk({tag, "_cout_hold"}, 64'(carry_out), 64'(ec));
  endtask

  initial begin
    int done_pos[$];
    logic [W-1:0] done_sum[$];
    logic         done_co[$];
    int           late_done;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(carry_out), 64'(0));
    rst = 1'b0;

    run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op("3c55", 8'h3C, 8'h55, 1'b0, 8'h91, 1'b0);
    run_op("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub0507", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
    run_op("sub0705", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
`else
    run_op("sub0507", 8'h05, 8'h07, 1'b1, 8'h0C, 1'b0);
    run_op("sub0705", 8'h07, 8'h05, 1'b1, 8'h0C, 1'b0);
`endif

    // start held high; operands change mid-RUN and again for the second op
    @(negedge clk);
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        done_pos.push_back(i);
        done_sum.push_back(sum);
        done_co.push_back(carry_out);
      end
      if (i == 3) begin a = 8'hF0; b = 8'h01; end
      if (i == 20) start = 1'b0;
    end
    chk("held_done_cnt", 64'(done_pos.size()), 64'(2));
    if (done_pos.size() == 2) begin
      chk("held_first_pos", 64'(done_pos[0]), 64'(9));
      chk("held_spacing", 64'(done_pos[1] - done_pos[0]), 64'(W + 2));
      chk("held_first_sum", 64'(done_sum[0]), 64'(8'h33));
      chk("held_first_cout", 64'(done_co[0]), 64'(0));
      chk("held_second_sum", 64'(done_sum[1]), 64'(8'hF1));
    end
    repeat (12) @(negedge clk);

    // reset while bit 4 is being processed
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 4; i++) @(negedge clk);
    chk("mid_busy_before_rst", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_sum", 64'(sum), 64'(0));
    chk("mid_rst_cout", 64'(carry_out), 64'(0));
    rst = 1'b0;
    late_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    chk("mid_rst_no_done", 64'(late_done), 64'(0));
    run_op("aa55", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
